sprite_renderer: RTL and testbench

Pixel-pipeline stage between the VGA timing generator and the board VGA pins. It converts raw hcount/vcount into sprite-ROM addresses for a movable WIDTH x HEIGHT sprite and absorbs the ROM read latency. It realigns hsync/vsync/blank with the returned pixel data and drives the 4-bit RGB and active-low sync pins. Sprite position arrives over a valid/ready handshake and takes effect only at frame boundaries, so the image never tears.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_renderer_delay_pipe.sv | 25 ++
 rtl/sprite_renderer.sv | 121 ++++++++++++
 tb/tb_sprite_renderer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared widths, default geometry and the output pixel bundle for the sprite renderer.
package sprite_pkg;

    localparam int HC_W          = 11;
    localparam int VC_W          = 10;
    localparam int COLOR_W       = 12;
    localparam int H_ACTIVE_DFLT = 1024;
    localparam int V_ACTIVE_DFLT = 768;

    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic               hs;
        logic               vs;
        logic               blank;
    } pixel_t;

endpackage

// File: rtl/sprite_renderer_delay_pipe.sv
// Generic DEPTH-stage shift register, cleared by an asynchronous active-low reset.
module delay_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_in;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_renderer.sv
// Maps raw VGA counts to sprite-ROM addresses, realigns sync/blank with the ROM data
// and drives the VGA pins; sprite moves are double-buffered to frame boundaries.
module sprite_renderer #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 128,
    parameter int H_ACTIVE    = sprite_pkg::H_ACTIVE_DFLT,
    parameter int V_ACTIVE    = sprite_pkg::V_ACTIVE_DFLT,
    parameter int MEM_LATENCY = 2,
    parameter int COLOR_W     = sprite_pkg::COLOR_W
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [sprite_pkg::HC_W-1:0]     hcount_in,
    input  logic [sprite_pkg::VC_W-1:0]     vcount_in,
    input  logic                            hsync_in,
    input  logic                            vsync_in,
    input  logic                            blank_in,
    input  logic [sprite_pkg::HC_W-1:0]     pos_x_in,
    input  logic [sprite_pkg::VC_W-1:0]     pos_y_in,
    input  logic                            pos_valid_in,
    output logic                            pos_ready_out,
    output logic [$clog2(WIDTH*HEIGHT)-1:0] mem_addr_out,
    input  logic [COLOR_W-1:0]              mem_data_in,
    output logic [3:0]                      vga_r_out,
    output logic [3:0]                      vga_g_out,
    output logic [3:0]                      vga_b_out,
    output logic                            vga_hs_out,
    output logic                            vga_vs_out,
    output logic [15:0]                     frame_count_out
);
    import sprite_pkg::*;

    localparam int ADDR_W = $clog2(WIDTH*HEIGHT);
    localparam int XW     = $clog2(WIDTH);

    if (COLOR_W != 12 || H_ACTIVE > (1 << HC_W) || V_ACTIVE >= (1 << VC_W)) begin : g_bad_geometry
        $error("sprite_renderer: unsupported colour width or screen geometry");
    end

    logic [HC_W-1:0]   pos_x_q, pend_x_q;
    logic [VC_W-1:0]   pos_y_q, pend_y_q;
    logic              pend_valid_q;
    logic [15:0]       frame_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic signed [11:0] dx, dy;
    logic              in_sprite;
    logic              frame_edge, pos_fire;
    logic [3:0]        align_q;
    pixel_t            pix_q, pix_d;
    logic [COLOR_W-1:0] rgb;

    assign frame_edge = (vcount_in == VC_W'(V_ACTIVE)) && (hcount_in == '0);
    assign pos_fire   = pos_valid_in && !pend_valid_q;

    // 12-bit signed offsets cannot alias: both operands are at most 11 bits unsigned.
    always_comb begin
        dx        = $signed({1'b0, hcount_in}) - $signed({1'b0, pos_x_q});
        dy        = $signed({2'b0, vcount_in}) - $signed({2'b0, pos_y_q});
        in_sprite = (dx >= 0) && (int'(dx) < WIDTH) && (dy >= 0) && (int'(dy) < HEIGHT);
        addr_d    = in_sprite ? ADDR_W'((int'(dy) << XW) + int'(dx)) : '0;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            pend_valid_q <= 1'b0;
            frame_q      <= '0;
            addr_q       <= '0;
        end else begin
            addr_q <= addr_d;
            if (frame_edge) frame_q <= frame_q + 16'd1;
            // A pending move is consumed at the boundary; otherwise the slot may be filled.
            if (frame_edge && pend_valid_q) begin
                pos_x_q      <= pend_x_q;
                pos_y_q      <= pend_y_q;
                pend_valid_q <= 1'b0;
            end else if (pos_fire) begin
                pend_x_q     <= pos_x_in;
                pend_y_q     <= pos_y_in;
                pend_valid_q <= 1'b1;
            end
        end
    end

    delay_pipe #(
        .DEPTH (MEM_LATENCY + 1),
        .W     (4)
    ) u_align (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   ({in_sprite, hsync_in, vsync_in, blank_in}),
        .q_out  (align_q)
    );

    always_comb begin
        pix_d       = '0;
        pix_d.color = align_q[3] ? mem_data_in : '0;
        pix_d.hs    = align_q[2];
        pix_d.vs    = align_q[1];
        pix_d.blank = align_q[0];
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) pix_q <= '0;
        else         pix_q <= pix_d;
    end

    assign rgb             = pix_q.blank ? '0 : pix_q.color;
    assign vga_r_out       = rgb[11:8];
    assign vga_g_out       = rgb[7:4];
    assign vga_b_out       = rgb[3:0];
    assign vga_hs_out      = ~pix_q.hs;
    assign vga_vs_out      = ~pix_q.vs;
    assign mem_addr_out    = addr_q;
    assign pos_ready_out   = !pend_valid_q;
    assign frame_count_out = frame_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Self-checking bench for sprite_renderer: behavioural sprite/handshake model plus a ROM model.
module tb_sprite_renderer;

    localparam int WIDTH    = 128;
    localparam int HEIGHT   = 128;
    localparam int V_ACTIVE = 768;

    typedef struct {
        int h; int v; bit hs; bit vs; bit bl; bit pv; int px; int py;
    } stim_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b1;
    logic [10:0] pos_x_in = '0;
    logic [9:0]  pos_y_in = '0;
    logic        pos_valid_in = 1'b0;
    logic        pos_ready_out;
    logic [13:0] mem_addr_out;
    logic [11:0] mem_data_in;
    logic [3:0]  vga_r_out, vga_g_out, vga_b_out;
    logic        vga_hs_out, vga_vs_out;
    logic [15:0] frame_count_out;

    sprite_renderer dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .pos_valid_in(pos_valid_in),
        .pos_ready_out(pos_ready_out), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
        .vga_r_out(vga_r_out), .vga_g_out(vga_g_out), .vga_b_out(vga_b_out),
        .vga_hs_out(vga_hs_out), .vga_vs_out(vga_vs_out), .frame_count_out(frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Sprite ROM with a two-cycle read latency.
    logic [11:0] rom_mem [16384];
    logic [13:0] rom_a1 = '0, rom_a2 = '0;
    always @(posedge clk_in) begin
        rom_a1 <= mem_addr_out;
        rom_a2 <= rom_a1;
    end
    assign mem_data_in = rom_mem[rom_a2];

    int m_pos_x, m_pos_y, m_pend_x, m_pend_y, m_frames;
    bit m_pend;
    logic [13:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic int sprite_addr(int h, int v);
        int dx = h - m_pos_x;
        int dy = v - m_pos_y;
        if (dx >= 0 && dx < WIDTH && dy >= 0 && dy < HEIGHT) return dy * WIDTH + dx;
        return -1;
    endfunction

    task automatic set_idle();
        hcount_in = 11'd1100; vcount_in = 10'd780;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b1; pos_valid_in = 1'b0;
    endtask

    task automatic model_reset();
        m_pos_x = 0; m_pos_y = 0; m_pend = 0; m_frames = 0;
        exp_q.delete();
        repeat (3) exp_q.push_back(14'h3000);
    endtask

    task automatic drive_cycle(input stim_t s, output bit chk, output logic [13:0] exp_vga,
                               output logic [13:0] exp_addr);
        int a;
        logic [11:0] col;
        bit boundary, fire;
        @(negedge clk_in);
        hcount_in = 11'(s.h); vcount_in = 10'(s.v);
        hsync_in = s.hs; vsync_in = s.vs; blank_in = s.bl;
        pos_valid_in = s.pv; pos_x_in = 11'(s.px); pos_y_in = 10'(s.py);
        a = sprite_addr(s.h, s.v);
        exp_addr = (a < 0) ? 14'd0 : 14'(a);
        col = (a >= 0 && !s.bl) ? rom_mem[a] : 12'h000;
        exp_q.push_back({~s.hs, ~s.vs, col});
        boundary = (s.v == V_ACTIVE) && (s.h == 0);
        fire = s.pv && !m_pend;
        if (boundary) m_frames = (m_frames + 1) % 65536;
        if (boundary && m_pend) begin
            m_pos_x = m_pend_x; m_pos_y = m_pend_y; m_pend = 0;
        end else if (fire) begin
            m_pend_x = s.px; m_pend_y = s.py; m_pend = 1;
        end
        @(posedge clk_in);
        #1;
        chk = 0;
        exp_vga = '0;
        if (exp_q.size() >= 4) begin
            exp_vga = exp_q.pop_front();
            chk = 1;
        end
    endtask

    function automatic stim_t mk(int h, int v, bit hs, bit vs, bit bl, bit pv, int px, int py);
        stim_t s;
        s.h = h; s.v = v; s.hs = hs; s.vs = vs; s.bl = bl; s.pv = pv; s.px = px; s.py = py;
        return s;
    endfunction

    task automatic test_reset();
        stim_t tab[$];
        bit chk;
        logic [13:0] ev, ea;
        @(negedge clk_in);
        set_idle();
        rst_in = 1'b1;
        model_reset();
        tab.push_back(mk(10, 10, 0, 0, 0, 1, 100, 50));
        tab.push_back(mk(0, 768, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk(20, 10, 0, 0, 0, 1, 200, 60));
        tab.push_back(mk(110, 60, 1, 0, 0, 0, 0, 0));
        tab.push_back(mk(120, 70, 0, 0, 0, 0, 0, 0));
        foreach (tab[i]) begin
            drive_cycle(tab[i], chk, ev, ea);
            n_checks++;
            if (mem_addr_out !== ea) begin
                n_errors++; $display("FAIL pre_reset_addr got=%0d exp=%0d", mem_addr_out, ea);
            end
            if (chk) begin
                n_checks++;
                if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                    n_errors++;
                    $display("FAIL pre_reset_vga got=%h exp=%h", {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
                end
            end
        end
        #3 rst_in = 1'b0;
        #1;
        n_checks++;
        if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out, pos_ready_out} !== 15'h6001
            || frame_count_out !== 16'd0 || mem_addr_out !== 14'd0) begin
            n_errors++;
            $display("FAIL async_reset got hs=%b vs=%b rgb=%h rdy=%b fc=%0d addr=%0d exp hs=1 vs=1 rgb=000 rdy=1 fc=0 addr=0",
                     vga_hs_out, vga_vs_out, {vga_r_out, vga_g_out, vga_b_out}, pos_ready_out,
                     frame_count_out, mem_addr_out);
        end
        repeat (2) @(negedge clk_in);
        set_idle();
        rst_in = 1'b1;
        model_reset();
        rom_mem[0] = 12'hFFF;
        tab.delete();
        tab.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        repeat (3) tab.push_back(mk(1100, 780, 0, 0, 1, 0, 0, 0));
        foreach (tab[i]) begin
            drive_cycle(tab[i], chk, ev, ea);
            if (chk) begin
                n_checks++;
                if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                    n_errors++;
                    $display("FAIL post_reset_vga step=%0d got=%h exp=%h", i, {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
                end
            end
        end
    endtask

    task automatic test_address();
        stim_t tab[$];
        bit chk;
        logic [13:0] ev, ea;
        rom_mem[389] = 12'hABC;
        tab.push_back(mk(5, 3, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(128, 3, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(10, 10, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(127, 127, 1, 1, 0, 0, 0, 0));
        tab.push_back(mk(0, 128, 0, 0, 0, 0, 0, 0));
        repeat (3) tab.push_back(mk(1100, 780, 0, 0, 1, 0, 0, 0));
        foreach (tab[i]) begin
            drive_cycle(tab[i], chk, ev, ea);
            n_checks++;
            if (mem_addr_out !== ea) begin
                n_errors++; $display("FAIL address_addr step=%0d got=%0d exp=%0d", i, mem_addr_out, ea);
            end
            if (chk) begin
                n_checks++;
                if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                    n_errors++;
                    $display("FAIL address_vga step=%0d got=%h exp=%h", i, {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
                end
            end
        end
    endtask

    task automatic test_move();
        stim_t tab[$];
        bit chk;
        logic [13:0] ev, ea;
        tab.push_back(mk(20, 20, 0, 0, 0, 1, 100, 50));
        tab.push_back(mk(100, 50, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(30, 30, 0, 0, 0, 1, 400, 400));
        tab.push_back(mk(0, 768, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk(100, 50, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(101, 51, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(99, 50, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(0, 768, 0, 1, 1, 1, 300, 200));
        tab.push_back(mk(101, 51, 0, 0, 0, 1, 500, 500));
        tab.push_back(mk(0, 768, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk(300, 200, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(101, 51, 0, 0, 0, 0, 0, 0));
        repeat (3) tab.push_back(mk(1100, 780, 0, 0, 1, 0, 0, 0));
        foreach (tab[i]) begin
            drive_cycle(tab[i], chk, ev, ea);
            n_checks++;
            if (mem_addr_out !== ea || pos_ready_out !== !m_pend || frame_count_out !== 16'(m_frames)) begin
                n_errors++;
                $display("FAIL move_state step=%0d got addr=%0d rdy=%b fc=%0d exp addr=%0d rdy=%b fc=%0d",
                         i, mem_addr_out, pos_ready_out, frame_count_out, ea, !m_pend, m_frames);
            end
            if (chk) begin
                n_checks++;
                if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                    n_errors++;
                    $display("FAIL move_vga step=%0d got=%h exp=%h", i, {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
                end
            end
        end
    endtask

    task automatic test_offscreen();
        stim_t tab[$];
        bit chk;
        logic [13:0] ev, ea;
        tab.push_back(mk(40, 40, 0, 0, 0, 1, 2000, 0));
        tab.push_back(mk(0, 768, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(2047, 5, 0, 0, 1, 0, 0, 0));
        tab.push_back(mk(50, 50, 0, 0, 0, 1, 1000, 0));
        tab.push_back(mk(0, 768, 0, 1, 1, 0, 0, 0));
        tab.push_back(mk(1023, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(999, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0));
        tab.push_back(mk(1127, 127, 0, 0, 1, 0, 0, 0));
        repeat (3) tab.push_back(mk(1100, 780, 0, 0, 1, 0, 0, 0));
        foreach (tab[i]) begin
            drive_cycle(tab[i], chk, ev, ea);
            n_checks++;
            if (mem_addr_out !== ea || pos_ready_out !== !m_pend) begin
                n_errors++;
                $display("FAIL offscreen_state step=%0d got addr=%0d rdy=%b exp addr=%0d rdy=%b",
                         i, mem_addr_out, pos_ready_out, ea, !m_pend);
            end
            if (chk) begin
                n_checks++;
                if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                    n_errors++;
                    $display("FAIL offscreen_vga step=%0d got=%h exp=%h", i, {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
                end
            end
        end
    endtask

    task automatic test_random();
        stim_t s;
        bit chk;
        logic [13:0] ev, ea;
        int h, v;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                h = 0; v = V_ACTIVE;
            end else begin
                h = m_pos_x + int'($urandom_range(0, 170)) - 20;
                v = m_pos_y + int'($urandom_range(0, 170)) - 20;
                h = (h < 0) ? 0 : (h > 2047 ? 2047 : h);
                v = (v < 0) ? 0 : (v > 1023 ? 1023 : v);
            end
            s = mk(h, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                   int'($urandom_range(0, 1200)), int'($urandom_range(0, 800)));
            drive_cycle(s, chk, ev, ea);
            n_checks++;
            if (mem_addr_out !== ea || pos_ready_out !== !m_pend || frame_count_out !== 16'(m_frames)) begin
                n_errors++;
                $display("FAIL random_state i=%0d got addr=%0d rdy=%b fc=%0d exp addr=%0d rdy=%b fc=%0d",
                         i, mem_addr_out, pos_ready_out, frame_count_out, ea, !m_pend, m_frames);
            end
            if (chk) begin
                n_checks++;
                if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                    n_errors++;
                    $display("FAIL random_vga i=%0d got=%h exp=%h", i, {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
                end
            end
        end
    endtask

    task automatic test_frame_wrap();
        bit chk;
        logic [13:0] ev, ea;
        int n;
        n = 65535 - m_frames;
        for (int i = 0; i < n; i++) drive_cycle(mk(0, V_ACTIVE, 0, 1, 1, 0, 0, 0), chk, ev, ea);
        n_checks++;
        if (frame_count_out !== 16'(m_frames)) begin
            n_errors++; $display("FAIL frame_before_wrap got=%h exp=%h", frame_count_out, 16'(m_frames));
        end
        drive_cycle(mk(0, V_ACTIVE, 0, 1, 1, 0, 0, 0), chk, ev, ea);
        n_checks++;
        if (frame_count_out !== 16'(m_frames)) begin
            n_errors++; $display("FAIL frame_wrap got=%h exp=%h", frame_count_out, 16'(m_frames));
        end
        if (chk) begin
            n_checks++;
            if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== ev) begin
                n_errors++;
                $display("FAIL frame_wrap_vga got=%h exp=%h", {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, ev);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) rom_mem[i] = 12'($urandom_range(0, 4095));
        #2;
        n_checks++;
        if ({vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out} !== 14'h3000
            || pos_ready_out !== 1'b1 || frame_count_out !== 16'd0 || mem_addr_out !== 14'd0) begin
            n_errors++;
            $display("FAIL initial_reset got vga=%h rdy=%b fc=%0d addr=%0d exp vga=3000 rdy=1 fc=0 addr=0",
                     {vga_hs_out, vga_vs_out, vga_r_out, vga_g_out, vga_b_out}, pos_ready_out,
                     frame_count_out, mem_addr_out);
        end
        test_reset();
        test_address();
        test_move();
        test_offscreen();
        test_random();
        test_frame_wrap();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
